// File: rtl/fifo_sync_param_pkg.sv
// Shared sizing helpers and parameter legality checks for the parametrised synchronous FIFO.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Data/handshake bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = fifo_pkg::cnt_w(DEPTH);

    logic [WIDTH-1:0] din;
    logic             trig_write;
    logic             trig_read;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output din, trig_write, trig_read, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  din, trig_write, trig_read, clr_err,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_ptr.sv
// Pointer, occupancy, status-flag and sticky-error bookkeeping for the synchronous FIFO.
module fifo_sync_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trig_write,
    input  logic                       trig_read,
    input  logic                       clr_err,
    output logic                       wr_ok,
    output logic                       rd_ok,
    output logic [addr_w(DEPTH)-1:0]   waddr,
    output logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    logic [ADDR_W:0]  wptr_reg, rptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg, underflow_reg;

    // A read at full frees the slot the concurrent write lands in.
    assign rd_ok = trig_read & ~empty;
    assign wr_ok = trig_write & (~full | rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
            if (rd_ok) rptr_reg <= rptr_reg + 1'b1;
            if (wr_ok && !rd_ok)
                count_reg <= count_reg + 1'b1;
            else if (rd_ok && !wr_ok)
                count_reg <= count_reg - 1'b1;
            // Error set takes priority over a same-cycle clear.
            if (trig_write && !wr_ok)
                overflow_reg <= 1'b1;
            else if (clr_err)
                overflow_reg <= 1'b0;
            if (trig_read && empty)
                underflow_reg <= 1'b1;
            else if (clr_err)
                underflow_reg <= 1'b0;
        end
    end

    assign waddr        = wptr_reg[ADDR_W-1:0];
    assign raddr        = rptr_reg[ADDR_W-1:0];
    assign count        = count_reg;
    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: storage array plus standard or first-word-fall-through read port.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int ADDR_W = addr_w(DEPTH);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of two >= 2");
        end
        if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
            $error("fifo_sync_param: AF_THRESH/AE_THRESH out of range");
        end
    endgenerate

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  dout_reg;
    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] waddr, raddr;

    fifo_sync_ptr #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig_write   (bus.trig_write),
        .trig_read    (bus.trig_read),
        .clr_err      (bus.clr_err),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (bus.count),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr] <= bus.din;
    end

    // Last word read; also serves as the stable FWFT value while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout_reg <= '0;
        else if (rd_ok)
            dout_reg <= mem[raddr];
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.dout = bus.empty ? dout_reg : mem[raddr];
        end else begin : g_std
            assign bus.dout = dout_reg;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench driving a standard-read and an FWFT instance of the FIFO with identical stimulus.
module tb_fifo_sync_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(16)) if0 ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(16)) if1 ();

    assign if0.din = din;  assign if0.trig_write = wr;  assign if0.trig_read = rd;  assign if0.clr_err = clr;
    assign if1.din = din;  assign if1.trig_write = wr;  assign if1.trig_read = rd;  assign if1.clr_err = clr;

    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int c);
        chk({tag, " count0"}, 32'(if0.count), 32'(c));
        chk({tag, " count1"}, 32'(if1.count), 32'(c));
        chk({tag, " full0"},  32'(if0.full),  32'(c == 16));
        chk({tag, " full1"},  32'(if1.full),  32'(c == 16));
        chk({tag, " empty0"}, 32'(if0.empty), 32'(c == 0));
        chk({tag, " empty1"}, 32'(if1.empty), 32'(c == 0));
        chk({tag, " af0"},    32'(if0.almost_full),  32'(c >= 12));
        chk({tag, " af1"},    32'(if1.almost_full),  32'(c >= 12));
        chk({tag, " ae0"},    32'(if0.almost_empty), 32'(c <= 2));
        chk({tag, " ae1"},    32'(if1.almost_empty), 32'(c <= 2));
    endtask

    task automatic chk_err(input string tag, input logic ovf, input logic unf);
        chk({tag, " ovf0"}, 32'(if0.overflow),  32'(ovf));
        chk({tag, " ovf1"}, 32'(if1.overflow),  32'(ovf));
        chk({tag, " unf0"}, 32'(if0.underflow), 32'(unf));
        chk({tag, " unf1"}, 32'(if1.underflow), 32'(unf));
    endtask

    // One clock with the given strobes; returns 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; din = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        $display("txn t=%0t wr=%0b rd=%0b din=%02h -> count=%0d dout0=%02h dout1=%02h ovf=%0b unf=%0b",
                 $time, w, r, d, if0.count, if0.dout, if1.dout, if0.overflow, if0.underflow);
    endtask

    initial begin
        // 1 reset held with strobes active
        wr = 1'b1; rd = 1'b1; din = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_flags("reset", 0);
        chk("reset dout0", 32'(if0.dout), 32'h00);
        chk("reset dout1", 32'(if1.dout), 32'h00);
        chk_err("reset", 1'b0, 1'b0);
        wr = 1'b0; rd = 1'b0;
        rst_n = 1'b1;

        // 2 fill
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk_flags($sformatf("fill%0d", i), i + 1);
            chk("fill head1", 32'(if1.dout), 32'h00);
        end
        cyc(1'b1, 1'b0, 8'h10);
        chk_flags("overfill", 16);
        chk_err("overfill", 1'b1, 1'b0);

        // 3 drain
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain head1 %0d", i), 32'(if1.dout), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain dout0 %0d", i), 32'(if0.dout), 32'(i));
            chk_flags($sformatf("drain%0d", i), 15 - i);
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk_err("underread", 1'b1, 1'b1);
        chk("underread dout0", 32'(if0.dout), 32'h0F);
        chk("underread dout1", 32'(if1.dout), 32'h0F);
        clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk_err("clr_err", 1'b0, 1'b0);

        // 4 wrap with steady occupancy of 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        chk_flags("wrap start", 5);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("wrap head1 %0d", k), 32'(if1.dout), 32'(8'h20 + k));
            cyc(1'b1, 1'b1, 8'(8'h25 + k));
            chk($sformatf("wrap dout0 %0d", k), 32'(if0.dout), 32'(8'h20 + k));
            chk($sformatf("wrap count %0d", k), 32'(if0.count), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap tail %0d", i), 32'(if0.dout), 32'(8'h48 + i));
        end
        chk_flags("wrap end", 0);
        chk_err("wrap end", 1'b0, 1'b0);

        // 5 boundaries: read+write at full, then at empty
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        cyc(1'b1, 1'b1, 8'h60);
        chk_flags("rw full", 16);
        chk_err("rw full", 1'b0, 1'b0);
        chk("rw full dout0", 32'(if0.dout), 32'h50);
        chk("rw full head1", 32'(if1.dout), 32'h51);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("post full %0d", i), 32'(if0.dout), 32'(8'h51 + i));
        end
        cyc(1'b1, 1'b1, 8'h77);
        chk_flags("rw empty", 1);
        chk_err("rw empty", 1'b0, 1'b1);
        chk("rw empty dout0", 32'(if0.dout), 32'h60);
        chk("rw empty head1", 32'(if1.dout), 32'h77);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rw empty read0", 32'(if0.dout), 32'h77);
        chk_flags("rw empty read", 0);

        // 6 asynchronous reset mid-burst
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        chk_flags("pre async", 9);
        #2 rst_n = 1'b0;
        #1;
        chk_flags("async rst", 0);
        chk("async dout0", 32'(if0.dout), 32'h00);
        chk("async dout1", 32'(if1.dout), 32'h00);
        chk_err("async rst", 1'b0, 1'b0);
        #4 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'hA5);
        chk("post rst head1", 32'(if1.dout), 32'hA5);
        chk_flags("post rst wr", 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post rst dout0", 32'(if0.dout), 32'hA5);
        chk_flags("post rst rd", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
